// File: rtl/microseq.sv
// microseq: Am2910-style micro-address sequencer with a LIFO stack and loop counter
module microseq #(
    parameter int AW = 6,
    parameter int SD = 5
) (
    input  logic          cp,
    input  logic          reset_lo,
    input  logic [2:0]    ins,
    input  logic          cc_lo,
    input  logic          ccen_lo,
    input  logic          ci,
    input  logic          rld_lo,
    input  logic [AW-1:0] d,
    output logic [AW-1:0] y,
    output logic          full_lo,
    output logic          empty_lo
);
    localparam int SPW = $clog2(SD + 1);
    localparam logic [SPW-1:0] SP_MAX = SPW'(SD);
    logic [AW-1:0]  upc, cnt, top;
    logic [AW-1:0]  stk [SD];
    logic [SPW-1:0] sp, sp_top, sp_wr;
    logic           pass, push, pop, clr, dec, load;
    assign pass     = ccen_lo | ~cc_lo;
    assign full_lo  = (sp != SP_MAX);
    assign empty_lo = (sp != '0);
    assign sp_top   = sp - SPW'(1);
    // a push into a full stack lands on the top entry instead of growing it
    assign sp_wr    = (sp == SP_MAX) ? SP_MAX - SPW'(1) : sp;
    assign top      = (sp == '0) ? '0 : stk[sp_top];
    // instruction decode: next-address select and stack/counter controls
    always_comb begin
        y    = upc;
        push = 1'b0;
        pop  = 1'b0;
        clr  = 1'b0;
        dec  = 1'b0;
        load = 1'b0;
        case (ins)
            3'd0: begin y = '0; clr = 1'b1; end
            3'd1: begin y = pass ? d : upc; push = pass; end
            3'd2: y = d;
            3'd3: y = pass ? d : upc;
            3'd4: begin push = 1'b1; load = pass; end
            3'd5: begin y = (cnt != '0) ? top : upc; dec = (cnt != '0); pop = (cnt == '0); end
            3'd6: begin y = pass ? top : upc; pop = pass; end
            default: ;
        endcase
        if (!reset_lo) y = '0;
    end
    // uPC, stack pointer and loop counter; reset overrides every instruction
    always_ff @(posedge cp) begin
        if (!reset_lo) begin
            upc <= '0;
            sp  <= '0;
            cnt <= '0;
        end else begin
            upc <= y + AW'(ci);
            if (clr) sp <= '0;
            else if (push) sp <= (sp == SP_MAX) ? sp : sp + SPW'(1);
            else if (pop) sp <= (sp == '0) ? sp : sp - SPW'(1);
            if (!rld_lo || load) cnt <= d;
            else if (dec) cnt <= cnt - AW'(1);
        end
    end
    // stack storage needs no reset; only entries below sp are ever read
    always_ff @(posedge cp) begin
        if (reset_lo && push) stk[sp_wr] <= upc;
    end
endmodule

// File: tb/tb_microseq.sv
// tb_microseq: vector table plus hand-written loop sequence for the micro-address sequencer
module tb_microseq;
    logic       cp = 1'b0;
    logic       reset_lo, cc_lo, ccen_lo, ci, rld_lo;
    logic [2:0] ins;
    logic [5:0] d, y;
    logic       full_lo, empty_lo;

    always #5 cp = ~cp;

    microseq #(.AW(6), .SD(5)) dut (
        .cp(cp), .reset_lo(reset_lo), .ins(ins), .cc_lo(cc_lo), .ccen_lo(ccen_lo),
        .ci(ci), .rld_lo(rld_lo), .d(d), .y(y), .full_lo(full_lo), .empty_lo(empty_lo)
    );

    typedef struct {
        logic       rst_n;
        logic [2:0] ins;
        logic       cc_lo, ccen_lo, ci, rld_lo;
        logic [5:0] d;
        logic [5:0] ey;
        logic       ef, ee, cf;
    } vec_t;

    typedef struct {
        int         idx;
        logic [5:0] ey;
        logic       ef, ee, cf;
    } exp_t;

    localparam logic [2:0] JZ = 0, CJS = 1, JMAP = 2, CJP = 3, PUSH = 4, RFCT = 5, CRTN = 6, CONT = 7;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void v(input logic r, input logic [2:0] i, input logic c, input logic ce,
                              input logic cin, input logic rl, input logic [5:0] dd,
                              input logic [5:0] ey, input logic ef, input logic ee, input logic cf);
        vec_t t;
        t = '{r, i, c, ce, cin, rl, dd, ey, ef, ee, cf};
        vecs.push_back(t);
    endfunction

    task automatic step(input logic [2:0] i, input logic c, input logic ce, input logic cin,
                        input logic rl, input logic [5:0] dd);
        @(posedge cp);
        #2;
        reset_lo = 1'b1; ins = i; cc_lo = c; ccen_lo = ce; ci = cin; rld_lo = rl; d = dd;
        #2;
    endtask

    initial begin
        exp_t e;
        int   iters;
        bit   exited;
        reset_lo = 1'b0; ins = CONT; cc_lo = 1'b1; ccen_lo = 1'b1; ci = 1'b1; rld_lo = 1'b1; d = 6'h2A;
        // reset held: y forced to 0
        v(0, CONT, 1, 1, 1, 1, 6'h2A, 6'h00, 1, 0, 0);
        v(0, CONT, 1, 1, 1, 1, 6'h2A, 6'h00, 1, 0, 1);
        v(1, CONT, 1, 1, 1, 1, 6'h2A, 6'h00, 1, 0, 1);
        // uPC wrap
        v(1, JMAP, 1, 1, 0, 1, 6'h3E, 6'h3E, 1, 0, 1);
        v(1, CONT, 1, 1, 1, 1, 6'h00, 6'h3E, 1, 0, 1);
        v(1, CONT, 1, 1, 1, 1, 6'h00, 6'h3F, 1, 0, 1);
        v(1, CONT, 1, 1, 1, 1, 6'h00, 6'h00, 1, 0, 1);
        v(1, CONT, 1, 1, 1, 1, 6'h00, 6'h01, 1, 0, 1);
        // subroutine call and return
        v(1, JMAP, 1, 1, 0, 1, 6'h05, 6'h05, 1, 0, 1);
        v(1, CJS,  0, 1, 1, 1, 6'h20, 6'h20, 1, 0, 1);
        v(1, CONT, 1, 1, 1, 1, 6'h00, 6'h21, 1, 1, 1);
        v(1, CRTN, 0, 0, 1, 1, 6'h00, 6'h05, 1, 1, 1);
        v(1, CONT, 1, 1, 1, 1, 6'h00, 6'h06, 1, 0, 1);
        // failed CJS: no push
        v(1, JMAP, 1, 1, 0, 1, 6'h05, 6'h05, 1, 0, 1);
        v(1, CJS,  1, 0, 1, 1, 6'h20, 6'h05, 1, 0, 1);
        v(1, CONT, 1, 1, 1, 1, 6'h00, 6'h06, 1, 0, 1);
        // CJP with ccen forcing pass, fail, pass
        v(1, CJP,  1, 1, 1, 1, 6'h30, 6'h30, 1, 0, 1);
        v(1, CJP,  1, 0, 1, 1, 6'h12, 6'h31, 1, 0, 1);
        v(1, CJP,  0, 0, 1, 1, 6'h12, 6'h12, 1, 0, 1);
        // loop of 3 with PUSH d=2
        v(1, JMAP, 1, 1, 0, 1, 6'h10, 6'h10, 1, 0, 1);
        v(1, PUSH, 0, 0, 1, 1, 6'h02, 6'h10, 1, 0, 1);
        v(1, RFCT, 1, 1, 1, 1, 6'h00, 6'h10, 1, 1, 1);
        v(1, RFCT, 1, 1, 1, 1, 6'h00, 6'h10, 1, 1, 1);
        v(1, RFCT, 1, 1, 1, 1, 6'h00, 6'h11, 1, 1, 1);
        v(1, CONT, 1, 1, 1, 1, 6'h00, 6'h12, 1, 0, 1);
        // counter reload during RFCT
        v(1, PUSH, 0, 0, 1, 1, 6'h01, 6'h13, 1, 0, 1);
        v(1, RFCT, 1, 1, 1, 0, 6'h02, 6'h13, 1, 1, 1);
        v(1, RFCT, 1, 1, 1, 1, 6'h00, 6'h13, 1, 1, 1);
        v(1, RFCT, 1, 1, 1, 1, 6'h00, 6'h13, 1, 1, 1);
        v(1, RFCT, 1, 1, 1, 1, 6'h00, 6'h14, 1, 1, 1);
        v(1, CONT, 1, 1, 1, 1, 6'h00, 6'h15, 1, 0, 1);
        // failed PUSH leaves counter at 0
        v(1, PUSH, 1, 0, 1, 1, 6'h07, 6'h16, 1, 0, 1);
        v(1, RFCT, 1, 1, 1, 1, 6'h00, 6'h17, 1, 1, 1);
        v(1, CONT, 1, 1, 1, 1, 6'h00, 6'h18, 1, 0, 1);
        // six pushes into a five-deep stack
        v(1, CJS,  0, 0, 1, 1, 6'h20, 6'h20, 1, 0, 1);
        v(1, CJS,  0, 0, 1, 1, 6'h30, 6'h30, 1, 1, 1);
        v(1, CJS,  0, 0, 1, 1, 6'h08, 6'h08, 1, 1, 1);
        v(1, CJS,  0, 0, 1, 1, 6'h0C, 6'h0C, 1, 1, 1);
        v(1, CJS,  0, 0, 1, 1, 6'h2C, 6'h2C, 1, 1, 1);
        v(1, CJS,  0, 0, 1, 1, 6'h3A, 6'h3A, 0, 1, 1);
        v(1, CONT, 1, 1, 1, 1, 6'h00, 6'h3B, 0, 1, 1);
        // six pops
        v(1, CRTN, 0, 0, 1, 1, 6'h00, 6'h2D, 0, 1, 1);
        v(1, CRTN, 0, 0, 1, 1, 6'h00, 6'h09, 1, 1, 1);
        v(1, CRTN, 0, 0, 1, 1, 6'h00, 6'h31, 1, 1, 1);
        v(1, CRTN, 0, 0, 1, 1, 6'h00, 6'h21, 1, 1, 1);
        v(1, CRTN, 0, 0, 1, 1, 6'h00, 6'h19, 1, 1, 1);
        v(1, CRTN, 0, 0, 1, 1, 6'h00, 6'h00, 1, 0, 1);
        v(1, CONT, 1, 1, 1, 1, 6'h00, 6'h01, 1, 0, 1);
        // JZ clears the stack
        v(1, CJS,  0, 0, 1, 1, 6'h25, 6'h25, 1, 0, 1);
        v(1, JZ,   1, 1, 1, 1, 6'h00, 6'h00, 1, 1, 1);
        v(1, CONT, 1, 1, 1, 1, 6'h00, 6'h01, 1, 0, 1);
        // reset in the middle of a loop
        v(1, PUSH, 0, 0, 1, 1, 6'h03, 6'h02, 1, 0, 1);
        v(0, RFCT, 1, 1, 1, 1, 6'h00, 6'h00, 1, 1, 1);
        v(1, RFCT, 1, 1, 1, 1, 6'h00, 6'h00, 1, 0, 1);
        v(1, CONT, 1, 1, 1, 1, 6'h00, 6'h01, 1, 0, 1);
        // carry-in of 0 holds uPC
        v(1, CONT, 1, 1, 0, 1, 6'h00, 6'h02, 1, 0, 1);
        v(1, CONT, 1, 1, 1, 1, 6'h00, 6'h02, 1, 0, 1);

        for (int k = 0; k < vecs.size(); k++) begin
            @(posedge cp);
            #2;
            reset_lo = vecs[k].rst_n; ins = vecs[k].ins; cc_lo = vecs[k].cc_lo;
            ccen_lo = vecs[k].ccen_lo; ci = vecs[k].ci; rld_lo = vecs[k].rld_lo; d = vecs[k].d;
            sb.push_back('{k, vecs[k].ey, vecs[k].ef, vecs[k].ee, vecs[k].cf});
            #2;
            e = sb.pop_front();
            chk($sformatf("v%0d.y", e.idx), 32'(y), 32'(e.ey));
            if (e.cf) begin
                chk($sformatf("v%0d.full_lo", e.idx), 32'(full_lo), 32'(e.ef));
                chk($sformatf("v%0d.empty_lo", e.idx), 32'(empty_lo), 32'(e.ee));
            end
        end

        // loop loaded with 4: body at 0x20 entered once by PUSH, then 4 RFCT returns
        step(JMAP, 1, 1, 0, 1, 6'h20);
        chk("loop.jmap", 32'(y), 32'h20);
        step(PUSH, 0, 0, 1, 1, 6'h04);
        chk("loop.push", 32'(y), 32'h20);
        iters = 0;
        exited = 1'b0;
        for (int n = 0; n < 12 && !exited; n++) begin
            step(RFCT, 1, 1, 1, 1, 6'h00);
            if (y == 6'h20) iters++;
            else exited = 1'b1;
        end
        chk("loop.exited", 32'(exited), 32'd1);
        chk("loop.iters", 32'(iters), 32'd4);
        chk("loop.exit_y", 32'(y), 32'h21);
        step(CONT, 1, 1, 1, 1, 6'h00);
        chk("loop.after_y", 32'(y), 32'h22);
        chk("loop.after_empty", 32'(empty_lo), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
